// File: rtl/prefetch_dma_scheduler.sv
// DMA fill sequencer for the two ping-pong CNN prefetch buffers: round-robin grant,
// burst-split read commands, and registered steering of returning beats into the granted buffer.
module prefetch_dma_scheduler #(
    parameter int BEAT_BYTES = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  buffer0_state,
    input  logic [2:0]  buffer1_state,
    input  logic [31:0] start_address,
    input  logic [31:0] prefetch_length,
    output logic        prefetch_select,
    output logic        prefetch_enable,
    output logic        prefetch_write,
    output logic [63:0] data_in,
    output logic [31:0] data_in_address,
    output logic        prefetch_finish,
    output logic        dma_cmd_valid,
    input  logic        dma_cmd_ready,
    output logic [31:0] dma_cmd_addr,
    output logic [8:0]  dma_cmd_beats,
    input  logic        dma_rvalid,
    input  logic [63:0] dma_rdata,
    input  logic        dma_rlast,
    output logic        dma_rready,
    output logic        busy,
    output logic        protocol_err
);
    localparam int          SHIFT         = $clog2(BEAT_BYTES);
    localparam logic [31:0] BEAT_INC      = 32'(BEAT_BYTES);
    localparam logic [31:0] BURST_CAP     = 32'(MAX_BURST);
    localparam logic [2:0]  WAIT_PREFETCH = 3'b001;

    typedef enum logic [2:0] {IDLE, GRANT, CMD, DATA, FINISH} state_t;

    state_t      state_q;
    logic        select_q, enable_q, write_q, finish_q, cmd_valid_q, rready_q, err_q;
    logic        last_served_q;
    logic [63:0] data_q;
    logic [31:0] waddr_q, cmd_addr_q, addr_q, remaining_q;
    logic [8:0]  cmd_beats_q, burst_cnt_q;

    logic        req0_d, req1_d, grant_d, last_beat_d;
    logic [31:0] len_beats_d, addr_inc_d, rem_dec_d;

    function automatic logic [8:0] burst_beats(input logic [31:0] rem);
        return (rem > BURST_CAP) ? 9'(MAX_BURST) : rem[8:0];
    endfunction

    always_comb begin
        req0_d      = (buffer0_state == WAIT_PREFETCH);
        req1_d      = (buffer1_state == WAIT_PREFETCH);
        // On a tie the buffer not served last wins; otherwise the lone requester.
        grant_d     = (req0_d && req1_d) ? ~last_served_q : req1_d;
        len_beats_d = prefetch_length >> SHIFT;
        addr_inc_d  = addr_q + BEAT_INC;
        rem_dec_d   = remaining_q - 32'd1;
        last_beat_d = (burst_cnt_q == 9'd1);
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            select_q      <= 1'b0;
            enable_q      <= 1'b0;
            write_q       <= 1'b0;
            finish_q      <= 1'b0;
            cmd_valid_q   <= 1'b0;
            rready_q      <= 1'b0;
            err_q         <= 1'b0;
            last_served_q <= 1'b1;
            data_q        <= '0;
            waddr_q       <= '0;
            cmd_addr_q    <= '0;
            cmd_beats_q   <= '0;
            addr_q        <= '0;
            remaining_q   <= '0;
            burst_cnt_q   <= '0;
        end else begin
            enable_q <= 1'b0;
            write_q  <= 1'b0;
            finish_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_d || req1_d) begin
                        select_q <= grant_d;
                        enable_q <= 1'b1;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    addr_q      <= start_address;
                    remaining_q <= len_beats_d;
                    if (len_beats_d == 32'd0) begin
                        finish_q <= 1'b1;
                        state_q  <= FINISH;
                    end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_addr_q  <= start_address;
                        cmd_beats_q <= burst_beats(len_beats_d);
                        state_q     <= CMD;
                    end
                end
                CMD: begin
                    if (dma_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        burst_cnt_q <= cmd_beats_q;
                        rready_q    <= 1'b1;
                        state_q     <= DATA;
                    end
                end
                DATA: begin
                    if (dma_rvalid) begin
                        write_q     <= 1'b1;
                        data_q      <= dma_rdata;
                        waddr_q     <= addr_q;
                        addr_q      <= addr_inc_d;
                        remaining_q <= rem_dec_d;
                        burst_cnt_q <= burst_cnt_q - 9'd1;
                        // rlast is only cross-checked; the burst boundary comes from burst_cnt.
                        if (dma_rlast != last_beat_d) err_q <= 1'b1;
                        if (last_beat_d) begin
                            rready_q <= 1'b0;
                            if (rem_dec_d != 32'd0) begin
                                cmd_valid_q <= 1'b1;
                                cmd_addr_q  <= addr_inc_d;
                                cmd_beats_q <= burst_beats(rem_dec_d);
                                state_q     <= CMD;
                            end else begin
                                finish_q <= 1'b1;
                                state_q  <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    last_served_q <= select_q;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prefetch_select = select_q;
    assign prefetch_enable = enable_q;
    assign prefetch_write  = write_q;
    assign data_in         = data_q;
    assign data_in_address = waddr_q;
    assign prefetch_finish = finish_q;
    assign dma_cmd_valid   = cmd_valid_q;
    assign dma_cmd_addr    = cmd_addr_q;
    assign dma_cmd_beats   = cmd_beats_q;
    assign dma_rready      = rready_q;
    assign busy            = (state_q != IDLE);
    assign protocol_err    = err_q;

endmodule

// File: tb/tb_prefetch_dma_scheduler.sv
// Directed bench for prefetch_dma_scheduler: a cycle-stepped DMA responder and buffer-state
// driver feed the DUT while each scenario task compares grants, commands and writes.
module tb_prefetch_dma_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  buffer0_state, buffer1_state;
    logic [31:0] start_address, prefetch_length;
    logic        prefetch_select, prefetch_enable, prefetch_write, prefetch_finish;
    logic [63:0] data_in;
    logic [31:0] data_in_address;
    logic        dma_cmd_valid, dma_cmd_ready;
    logic [31:0] dma_cmd_addr;
    logic [8:0]  dma_cmd_beats;
    logic        dma_rvalid, dma_rlast, dma_rready;
    logic [63:0] dma_rdata;
    logic        busy, protocol_err;

    prefetch_dma_scheduler #(.BEAT_BYTES(8), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .buffer0_state(buffer0_state), .buffer1_state(buffer1_state),
        .start_address(start_address), .prefetch_length(prefetch_length),
        .prefetch_select(prefetch_select), .prefetch_enable(prefetch_enable),
        .prefetch_write(prefetch_write), .data_in(data_in), .data_in_address(data_in_address),
        .prefetch_finish(prefetch_finish),
        .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
        .dma_cmd_addr(dma_cmd_addr), .dma_cmd_beats(dma_cmd_beats),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_rlast(dma_rlast),
        .dma_rready(dma_rready), .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    logic [144:0] all_outs;
    assign all_outs = {prefetch_select, prefetch_enable, prefetch_write, data_in, data_in_address,
                       prefetch_finish, dma_cmd_valid, dma_cmd_addr, dma_cmd_beats, dma_rready,
                       busy, protocol_err};

    typedef struct {
        logic [31:0] addr;
        logic        last;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    beat_t       pend[$];
    logic [31:0] cmd_addr_log[$];
    logic [8:0]  cmd_beats_log[$];
    int          sel_log[$];
    int          en_log[$];
    int          fin_log[$];
    int          wr_count, first_cmd_cyc, last_wr_cyc, beat_idx;

    function automatic logic [63:0] beat_data(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        buffer0_state = 3'b000; buffer1_state = 3'b000;
        start_address = '0; prefetch_length = '0;
        dma_cmd_ready = 1'b0; dma_rvalid = 1'b0; dma_rdata = '0; dma_rlast = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Steps one cycle per negedge: samples DUT outputs, then drives the DMA channels and
    // decides which handshakes complete on the following posedge.
    task automatic run(input logic [31:0] start, input logic [31:0] len, input int n_fills,
                       input int ready_delay, input bit toggle, input int bad_beat,
                       input bit keep_req, input int abort_writes);
        int          cyc = 0;
        int          wait_cnt = 0;
        int          fins = 0;
        bit          cmd_pend = 1'b0;
        bit          phase = 1'b0;
        int          cur_sel = 0;
        logic [31:0] held_addr = '0;
        logic [8:0]  held_beats = '0;
        logic [31:0] exp_addr = start;
        pend.delete(); cmd_addr_log.delete(); cmd_beats_log.delete();
        sel_log.delete(); en_log.delete(); fin_log.delete();
        wr_count = 0; first_cmd_cyc = -1; last_wr_cyc = -1; beat_idx = 0;
        start_address = start; prefetch_length = len;
        while (fins < n_fills && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (prefetch_enable) begin
                cur_sel = int'(prefetch_select);
                sel_log.push_back(cur_sel);
                en_log.push_back(cyc);
                exp_addr = start;
                if (!keep_req) begin
                    if (prefetch_select) buffer1_state = 3'b010; else buffer0_state = 3'b010;
                end
            end
            if (prefetch_write) begin
                checks++;
                if (data_in_address !== exp_addr) begin
                    failures++;
                    $display("FAIL wr_addr beat %0d: got %h expected %h", wr_count, data_in_address, exp_addr);
                end
                checks++;
                if (data_in !== beat_data(exp_addr)) begin
                    failures++;
                    $display("FAIL wr_data beat %0d: got %h expected %h", wr_count, data_in, beat_data(exp_addr));
                end
                checks++;
                if (int'(prefetch_select) !== cur_sel) begin
                    failures++;
                    $display("FAIL wr_select beat %0d: got %0d expected %0d", wr_count, prefetch_select, cur_sel);
                end
                exp_addr = exp_addr + 32'd8;
                wr_count++;
                last_wr_cyc = cyc;
            end
            if (prefetch_finish) begin
                fins++;
                fin_log.push_back(cyc);
                if (!keep_req) begin
                    if (prefetch_select) buffer1_state = 3'b011; else buffer0_state = 3'b011;
                end
            end
            if (abort_writes > 0 && wr_count >= abort_writes) return;

            // Read-data channel: decided before this cycle's command is queued.
            if (pend.size() > 0 && (!toggle || phase)) begin
                dma_rvalid = 1'b1;
                dma_rdata  = beat_data(pend[0].addr);
                dma_rlast  = pend[0].last || (beat_idx + 1 == bad_beat);
            end else begin
                dma_rvalid = 1'b0;
                dma_rlast  = 1'b0;
            end
            phase = ~phase;
            if (dma_rvalid && dma_rready) begin
                void'(pend.pop_front());
                beat_idx++;
            end

            // Command channel with optional ready back-pressure.
            if (dma_cmd_valid) begin
                if (!cmd_pend) begin
                    cmd_pend = 1'b1; held_addr = dma_cmd_addr; held_beats = dma_cmd_beats; wait_cnt = 0;
                    if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
                end else begin
                    checks++;
                    if (dma_cmd_addr !== held_addr || dma_cmd_beats !== held_beats) begin
                        failures++;
                        $display("FAIL cmd_stable: got %h/%0d expected %h/%0d", dma_cmd_addr, dma_cmd_beats, held_addr, held_beats);
                    end
                end
                dma_cmd_ready = (wait_cnt >= ready_delay);
                wait_cnt++;
                if (dma_cmd_ready) begin
                    cmd_addr_log.push_back(held_addr);
                    cmd_beats_log.push_back(held_beats);
                    for (int i = 0; i < int'(held_beats); i++) begin
                        beat_t b;
                        b.addr = held_addr + 32'(i * 8);
                        b.last = (i == int'(held_beats) - 1);
                        pend.push_back(b);
                    end
                    cmd_pend = 1'b0;
                end
            end else begin
                checks++;
                if (cmd_pend) begin
                    failures++;
                    $display("FAIL cmd_drop: got valid=0 expected valid=1 before ready");
                end
                dma_cmd_ready = 1'b0;
            end
        end
        checks++;
        if (fins < n_fills) begin
            failures++;
            $display("FAIL fill_timeout: got %0d finishes expected %0d", fins, n_fills);
        end
        dma_cmd_ready = 1'b0; dma_rvalid = 1'b0; dma_rlast = 1'b0;
        buffer0_state = 3'b000; buffer1_state = 3'b000;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_fill();
        idle_cycles(2);
        buffer0_state = 3'b001;
        run(32'h1000, 32'd64, 1, 0, 1'b0, 0, 1'b0, 0);
        checks++;
        if (cmd_addr_log.size() != 1) begin
            failures++;
            $display("FAIL single_cmd_count: got %0d expected 1", cmd_addr_log.size());
        end else begin
            checks++;
            if (cmd_addr_log[0] !== 32'h1000 || cmd_beats_log[0] !== 9'd8) begin
                failures++;
                $display("FAIL single_cmd: got %h/%0d expected 00001000/8", cmd_addr_log[0], cmd_beats_log[0]);
            end
        end
        checks++;
        if (wr_count != 8) begin failures++; $display("FAIL single_writes: got %0d expected 8", wr_count); end
        checks++;
        if (sel_log.size() != 1 || en_log[0] != 1 || sel_log[0] != 0) begin
            failures++;
            $display("FAIL single_grant: got n=%0d cyc=%0d sel=%0d expected n=1 cyc=1 sel=0", sel_log.size(), en_log[0], sel_log[0]);
        end
        checks++;
        if (first_cmd_cyc != 2) begin failures++; $display("FAIL single_cmd_latency: got %0d expected 2", first_cmd_cyc); end
        checks++;
        if (fin_log.size() != 1 || fin_log[0] != last_wr_cyc) begin
            failures++;
            $display("FAIL single_finish: got n=%0d cyc=%0d expected n=1 cyc=%0d", fin_log.size(), fin_log[0], last_wr_cyc);
        end
        checks++;
        if (protocol_err !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", protocol_err); end
    endtask

    task automatic test_burst_split();
        logic [31:0] exp_a[3];
        logic [8:0]  exp_b[3];
        exp_a = '{32'h2000, 32'h2080, 32'h2100};
        exp_b = '{9'd16, 9'd16, 9'd5};
        idle_cycles(2);
        buffer1_state = 3'b001;
        run(32'h2000, 32'd300, 1, 0, 1'b0, 0, 1'b0, 0);
        checks++;
        if (cmd_addr_log.size() != 3) begin
            failures++;
            $display("FAIL split_cmd_count: got %0d expected 3", cmd_addr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cmd_addr_log[i] !== exp_a[i] || cmd_beats_log[i] !== exp_b[i]) begin
                    failures++;
                    $display("FAIL split_cmd%0d: got %h/%0d expected %h/%0d", i, cmd_addr_log[i], cmd_beats_log[i], exp_a[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (wr_count != 37) begin failures++; $display("FAIL split_writes: got %0d expected 37", wr_count); end
        checks++;
        if (sel_log.size() != 1 || sel_log[0] != 1) begin
            failures++;
            $display("FAIL split_select: got %0d expected 1", sel_log[0]);
        end
        checks++;
        if (fin_log.size() != 1 || fin_log[0] != last_wr_cyc) begin
            failures++;
            $display("FAIL split_finish: got cyc=%0d expected cyc=%0d", fin_log[0], last_wr_cyc);
        end
    endtask

    task automatic test_backpressure();
        idle_cycles(2);
        buffer0_state = 3'b001;
        run(32'h3000, 32'd160, 1, 5, 1'b1, 0, 1'b0, 0);
        checks++;
        if (cmd_addr_log.size() != 2) begin
            failures++;
            $display("FAIL bp_cmd_count: got %0d expected 2", cmd_addr_log.size());
        end else begin
            checks++;
            if (cmd_addr_log[1] !== 32'h3080 || cmd_beats_log[1] !== 9'd4) begin
                failures++;
                $display("FAIL bp_cmd1: got %h/%0d expected 00003080/4", cmd_addr_log[1], cmd_beats_log[1]);
            end
        end
        checks++;
        if (wr_count != 20) begin failures++; $display("FAIL bp_writes: got %0d expected 20", wr_count); end
    endtask

    task automatic test_zero_length();
        idle_cycles(2);
        buffer0_state = 3'b001;
        run(32'h7000, 32'd7, 1, 0, 1'b0, 0, 1'b0, 0);
        checks++;
        if (cmd_addr_log.size() != 0 || wr_count != 0) begin
            failures++;
            $display("FAIL zero_traffic: got cmds=%0d writes=%0d expected 0/0", cmd_addr_log.size(), wr_count);
        end
        checks++;
        if (en_log.size() != 1 || fin_log.size() != 1 || en_log[0] != 1 || fin_log[0] != 2) begin
            failures++;
            $display("FAIL zero_timing: got en=%0d fin=%0d expected en=1 fin=2", en_log[0], fin_log[0]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        idle_cycles(1);
        for (int r = 0; r < 2; r++) begin
            buffer0_state = 3'b001; buffer1_state = 3'b001;
            run(32'h8000, 32'd16, 2, 0, 1'b0, 0, 1'b0, 0);
            checks++;
            if (sel_log.size() != 2 || sel_log[0] != 0 || sel_log[1] != 1) begin
                failures++;
                $display("FAIL rr_round%0d: got %0d,%0d expected 0,1", r, sel_log[0], sel_log[1]);
            end
            idle_cycles(2);
        end
        // Both buffers keep requesting: ties must alternate, and regrant is 2 cycles after finish.
        buffer0_state = 3'b001; buffer1_state = 3'b001;
        run(32'h8100, 32'd16, 3, 0, 1'b0, 0, 1'b1, 0);
        checks++;
        if (sel_log.size() < 3 || sel_log[0] != 0 || sel_log[1] != 1 || sel_log[2] != 0) begin
            failures++;
            $display("FAIL rr_tie: got %0d,%0d,%0d expected 0,1,0", sel_log[0], sel_log[1], sel_log[2]);
        end
        checks++;
        if (en_log.size() < 2 || en_log[1] != fin_log[0] + 2) begin
            failures++;
            $display("FAIL rr_regrant: got %0d expected %0d", en_log[1], fin_log[0] + 2);
        end
    endtask

    task automatic test_bad_rlast();
        idle_cycles(2);
        checks++;
        if (protocol_err !== 1'b0) begin failures++; $display("FAIL err_pre: got %b expected 0", protocol_err); end
        buffer0_state = 3'b001;
        run(32'h5000, 32'd64, 1, 0, 1'b0, 3, 1'b0, 0);
        checks++;
        if (wr_count != 8) begin failures++; $display("FAIL err_writes: got %0d expected 8", wr_count); end
        checks++;
        if (protocol_err !== 1'b1) begin failures++; $display("FAIL err_set: got %b expected 1", protocol_err); end
        idle_cycles(2);
        buffer0_state = 3'b001;
        run(32'h5100, 32'd16, 1, 0, 1'b0, 0, 1'b0, 0);
        checks++;
        if (protocol_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", protocol_err); end
    endtask

    task automatic test_reset_mid_data();
        idle_cycles(2);
        buffer0_state = 3'b001;
        run(32'h6000, 32'd64, 1, 0, 1'b0, 0, 1'b0, 3);
        checks++;
        if (wr_count != 3) begin failures++; $display("FAIL mid_progress: got %0d expected 3", wr_count); end
        rst = 1'b1;
        buffer0_state = 3'b000;
        dma_rvalid = 1'b1; dma_rdata = 64'hDEAD_BEEF_0BAD_F00D; dma_rlast = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h expected 0", all_outs);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (prefetch_write !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_late_beat%0d: got write=%b busy=%b expected 0/0", i, prefetch_write, busy);
            end
        end
        dma_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_burst_split();
        test_backpressure();
        test_zero_length();
        test_round_robin();
        test_bad_rlast();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
